// File: rtl/key_input_conditioner_pkg.sv
// Shared definitions for the key input conditioner.
//   - key_state_e : per-key debounce FSM state encoding (2 bits).
//   - cnt_width() : counter width helper, never smaller than 1 bit.
// Optional build feature:
//   KEY_LONG_PRESS_EN - when defined, every key cell also counts how long the
//   key has been held and pulses long_o once per hold after LONG_CYCLES
//   cycles; the pulse also sets the sticky event flag. When undefined the
//   long-press port, counter and flops do not exist.
package key_input_conditioner_pkg;

  typedef enum logic [1:0] {
    KEY_ST_RELEASED     = 2'b00,
    KEY_ST_PRESS_PEND   = 2'b01,
    KEY_ST_PRESSED      = 2'b10,
    KEY_ST_RELEASE_PEND = 2'b11
  } key_state_e;

  // Bits needed to hold 0..n-1, clamped to at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, debounce FSM with counter, registered level
// and one-cycle press/release pulses.
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset
//   key_raw_i  - raw asynchronous key pin
//   key_o      - debounced level, 1 = pressed
//   press_o    - one-cycle pulse on an accepted press
//   release_o  - one-cycle pulse on an accepted release
//   long_o     - one-cycle long-hold pulse (only with KEY_LONG_PRESS_EN)
module key_debounce_cell
  import key_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYCLES     = 50000000
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic long_o
`endif
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed_s;
  key_state_e       state_q;
  key_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             key_q;
  logic             key_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Synchroniser; reset loads the released pin level so no false press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalised sample: 1 means pressed regardless of pin polarity.
  assign pressed_s = sync2_q ^ ACTIVE_LOW;

  // FSM, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= KEY_ST_RELEASED;
      cnt_q     <= '0;
      key_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state: a change is accepted only after an unbroken run of samples;
  // the counter stops at CNT_LAST, so it never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      KEY_ST_RELEASED: begin
        if (pressed_s) begin
          state_d = KEY_ST_PRESS_PEND;
          cnt_d   = '0;
        end
      end
      KEY_ST_PRESS_PEND: begin
        if (!pressed_s) begin
          state_d = KEY_ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KEY_ST_PRESSED;
          cnt_d   = '0;
          key_d   = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KEY_ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = KEY_ST_RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      KEY_ST_RELEASE_PEND: begin
        if (pressed_s) begin
          state_d = KEY_ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = KEY_ST_RELEASED;
          cnt_d     = '0;
          key_d     = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = KEY_ST_RELEASED;
        cnt_d   = '0;
        key_d   = 1'b0;
      end
    endcase
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned       LCNT_W    = cnt_width(LONG_CYCLES);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

  logic [LCNT_W-1:0] lcnt_q;
  logic [LCNT_W-1:0] lcnt_d;
  logic              long_q;
  logic              long_d;

  // Hold-time counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  // Counts while held, parks at LCNT_LAST so the pulse fires once per hold.
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (state_d == KEY_ST_RELEASED) begin
      lcnt_d = '0;
    end else if ((state_q == KEY_ST_PRESSED || state_q == KEY_ST_RELEASE_PEND) &&
                 (lcnt_q != LCNT_LAST)) begin
      lcnt_d = lcnt_q + LCNT_W'(1);
      long_d = (lcnt_d == LCNT_LAST);
    end
  end

  assign long_o = long_q;
`endif

endmodule

// File: rtl/key_input_conditioner.sv
// Key/touch front end feeding the SoC GPIO input vector: one debounce cell
// per key plus sticky press-event flags and the interrupt request.
// Optional feature macro: KEY_LONG_PRESS_EN (adds LONG_CYCLES and long_o).
// Ports:
//   clk_i      - system clock
//   rst_i      - synchronous active-high reset
//   key_raw_i  - raw asynchronous key pins
//   key_o      - debounced levels, 1 = pressed (drives gpio_in)
//   press_o    - one-cycle accepted-press pulses
//   release_o  - one-cycle accepted-release pulses
//   evt_o      - sticky press-event flags
//   evt_clr_i  - write-1-to-clear mask for evt_o
//   irq_o      - OR of evt_o
//   long_o     - long-hold pulses (only with KEY_LONG_PRESS_EN)
module key_input_conditioner
  import key_input_conditioner_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYCLES     = 50000000
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  output logic [NUM_KEYS-1:0] key_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic [NUM_KEYS-1:0] evt_o,
  input  logic [NUM_KEYS-1:0] evt_clr_i,
  output logic                irq_o
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic [NUM_KEYS-1:0] long_o
`endif
);

  logic [NUM_KEYS-1:0] evt_q;
  logic [NUM_KEYS-1:0] evt_set;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef KEY_LONG_PRESS_EN
      ,
      .LONG_CYCLES     (LONG_CYCLES)
`endif
    ) u_cell (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .key_raw_i (key_raw_i[g]),
      .key_o     (key_o[g]),
      .press_o   (press_o[g]),
      .release_o (release_o[g])
`ifdef KEY_LONG_PRESS_EN
      ,
      .long_o    (long_o[g])
`endif
    );
  end

`ifdef KEY_LONG_PRESS_EN
  assign evt_set = press_o | long_o;
`else
  assign evt_set = press_o;
`endif

  // Sticky flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q <= '0;
    end else begin
      evt_q <= (evt_q & ~evt_clr_i) | evt_set;
    end
  end

  assign evt_o = evt_q;

  // Reduction of flop outputs only, so the request cannot glitch.
  assign irq_o = |evt_q;

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Board-facing front end between the raw key/touch pins and the SoC GPIO input vector; replaces the direct pin-to-gpio_in tie.
- Per key: synchronises the asynchronous pin, debounces it with a per-key FSM and counter, and emits a stable level plus one-cycle press/release pulses.
- Collects sticky press events into an interrupt request for the core.

Parameters:
- NUM_KEYS, 5, number of key inputs (key[3:0] plus touch_key).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (20 ms at 50 MHz); legal range >= 2.
- ACTIVE_LOW, 1, 1 = raw pin low means pressed; 0 = raw pin high means pressed.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- key_raw_i  in  NUM_KEYS  raw asynchronous key pins.
- key_o  out  NUM_KEYS  debounced level, 1 = pressed; drives gpio_in[NUM_KEYS-1:0].
- press_o  out  NUM_KEYS  one-cycle pulse on an accepted press.
- release_o  out  NUM_KEYS  one-cycle pulse on an accepted release.
- evt_o  out  NUM_KEYS  sticky press-event flags.
- evt_clr_i  in  NUM_KEYS  per-key clear mask for evt_o; write-1-to-clear, one cycle.
- irq_o  out  1  OR of evt_o.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i high at a clk_i edge):
  - Sync flops load the released pin level: 1 if ACTIVE_LOW, else 0.
  - FSM goes to RELEASED; counter = 0.
  - key_o, press_o, release_o, evt_o and irq_o are all 0.
  - Reset mid-debounce discards the pending change; no pulse is generated.
- Sync: 2-flop synchroniser per key. Normalised sample s = sync2 XOR ACTIVE_LOW, so s = 1 means pressed.
- Counter: width $clog2(DEBOUNCE_CYCLES); saturating use only, never wraps.
- FSM per key, states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND:
  - RELEASED: s=1 -> PRESS_PEND, cnt=0. Otherwise stay.
  - PRESS_PEND:
    - s=0 -> RELEASED, cnt=0 (bounce rejected).
    - s=1 and cnt==DEBOUNCE_CYCLES-2 -> PRESSED; key_o<=1; press_o pulses next cycle.
    - Otherwise cnt++.
  - PRESSED: s=0 -> RELEASE_PEND, cnt=0.
  - RELEASE_PEND:
    - s=1 -> PRESSED (bounce rejected).
    - s=0 and cnt==DEBOUNCE_CYCLES-2 -> RELEASED; key_o<=0; release_o pulses.
    - Otherwise cnt++.
- Latency: key_o changes exactly DEBOUNCE_CYCLES cycles after the first qualifying s sample, i.e. 2+DEBOUNCE_CYCLES cycles after a clean pin edge.
- Pulses are registered and coincide with the key_o edge cycle. press_o and release_o are never high together for one key.
- evt_o[i]:
  - Set by press_o[i]; cleared by evt_clr_i[i].
  - Set wins if both occur in the same cycle.
  - Clearing an already-clear flag has no effect.
- irq_o: combinational OR of evt_o flops; glitch-free.
- Keys are fully independent; simultaneous presses on several keys each produce their own pulse and flag.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- When defined:
  - Adds parameter LONG_CYCLES (default 50000000) and output long_o[NUM_KEYS].
  - A second per-key counter runs while in PRESSED or RELEASE_PEND and clears on entering RELEASED.
  - long_o[i] pulses once when the counter reaches LONG_CYCLES-1; it does not repeat until the key is released.
  - long_o also sets evt_o.
- When undefined: no long_o port, no second counter, no extra flops.

Decomposition:
- Shared defines header holds:
  - the FSM state encodings KEY_ST_RELEASED/PRESS_PEND/PRESSED/RELEASE_PEND (2 bits);
  - the KEY_LONG_PRESS_EN documentation.
- Sub-module key_debounce_cell: one key covering sync, FSM, counter and pulses.
- The top generates NUM_KEYS cells and holds the evt/irq logic.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, NUM_KEYS=5):
- Reset, all pins high -> key_o=0, evt_o=0, irq_o=0, no pulses for 20 cycles.
- key_raw_i[0] falls and is held -> press_o[0] pulses once at cycle 6 after the edge; key_o[0]=1; evt_o[0]=1; irq_o=1.
- Bounce: pin low 3 cycles, high 1, then low held -> no early pulse; press occurs 6 cycles after the final fall.
- Release after the press held -> release_o[0] pulses once at cycle 6; key_o[0]=0; evt_o[0] stays 1.
- evt_clr_i=5'b00001 in the same cycle as a new press_o[0] -> evt_o[0] stays 1. evt_clr_i alone next cycle -> evt_o[0]=0, irq_o=0.
- rst_i asserted in PRESS_PEND for key 2 with the pin still low -> key_o[2]=0, no press pulse; re-qualifies 6 cycles after rst_i deasserts.
